alu_exec_unit: RTL

Execute-stage consumer of the 4-bit ALU control code produced by the ALU control decoder. It accepts an operation code and two operands through a valid/ready handshake. Single-cycle ops return a registered result in 1 cycle; MUL runs an iterative shift-add multiply. It drives result, zero flag (for branch compare) and an illegal-op flag to writeback/branch logic.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_iter.sv | 79 +++++++
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes exchanged with the ALU control
// decoder, and the state encoding of the execute-unit FSM.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1000;
  localparam logic [3:0] ALU_MUL     = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_HOLD     = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN cycles,
// low XLEN bits of the product. done is a one-cycle pulse once product is final.
// flush abandons the current multiply and clears the accumulator.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0]  mcand_r;
  logic [XLEN-1:0]  mplier_r;
  logic [XLEN-1:0]  acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [XLEN-1:0]  addend_s;

  // Partial product selected by the current multiplier LSB.
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {XLEN{1'b0}};
    end
  end

  // Load on start, then one shift-add step per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {XLEN{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (flush) begin
      acc_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= mcand_in;
      mplier_r <= mplier_in;
      acc_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      acc_r    <= acc_r + addend_s;
      mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
      cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_r == CNT_W'(XLEN-1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with registered result, optional
// iterative MUL, valid/ready in and out, zero and illegal flags.
// Optional feature macro: ALU_EXEC_MUL_EN (multiply path; 1001 is illegal otherwise).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_t          state_r;
  state_t          state_nxt_s;
  logic            accept_s;
  logic            is_mul_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] alu_res_s;
  logic            alu_ill_s;
  logic            mul_busy_s;
  logic            mul_done_s;
  logic [XLEN-1:0] mul_product_s;

  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic            illegal_r;
  logic            out_valid_r;
  logic            in_ready_r;
  logic [XLEN-1:0] result_nxt_s;
  logic            zero_nxt_s;
  logic            illegal_nxt_s;
  logic            out_valid_nxt_s;
  logic            in_ready_nxt_s;

  assign shamt_s  = op_b[4:0];
  assign accept_s = (state_r == ST_IDLE) && in_valid && !flush;

`ifdef ALU_EXEC_MUL_EN
  assign is_mul_s = (alu_control == ALU_MUL);

  alu_mul_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (accept_s && is_mul_s),
    .mcand_in  (op_a),
    .mplier_in (op_b),
    .busy      (mul_busy_s),
    .done      (mul_done_s),
    .product   (mul_product_s)
  );
`else
  assign is_mul_s      = 1'b0;
  assign mul_busy_s    = 1'b0;
  assign mul_done_s    = 1'b0;
  assign mul_product_s = {XLEN{1'b0}};
`endif

  // Single-cycle ALU; any unlisted code (and MUL, handled elsewhere) flags illegal.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    alu_ill_s = 1'b0;
    case (alu_control)
      ALU_AND:  alu_res_s = op_a & op_b;
      ALU_OR:   alu_res_s = op_a | op_b;
      ALU_ADD:  alu_res_s = op_a + op_b;
      ALU_XOR:  alu_res_s = op_a ^ op_b;
      ALU_SLL:  alu_res_s = op_a << shamt_s;
      ALU_SRL:  alu_res_s = op_a >> shamt_s;
      ALU_SUB:  alu_res_s = op_a - op_b;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_SRA:  alu_res_s = $unsigned($signed(op_a) >>> shamt_s);
      default: begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; flush overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = is_mul_s ? ST_MUL_BUSY : ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL_BUSY: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (mul_done_s) begin
          state_nxt_s = ST_HOLD;
        end else if (!mul_busy_s) begin
          // Multiplier idle without finishing: recover instead of hanging.
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL_BUSY;
        end
      end
      ST_HOLD: begin
        if (flush || out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; result/flags hold unless updated.
  always_comb begin
    result_nxt_s    = result_r;
    zero_nxt_s      = zero_r;
    illegal_nxt_s   = illegal_r;
    out_valid_nxt_s = (state_nxt_s == ST_HOLD);
    in_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    if (accept_s && !is_mul_s) begin
      result_nxt_s  = alu_res_s;
      zero_nxt_s    = (alu_res_s == {XLEN{1'b0}});
      illegal_nxt_s = alu_ill_s;
    end else if ((state_r == ST_MUL_BUSY) && mul_done_s && !flush) begin
      result_nxt_s  = mul_product_s;
      zero_nxt_s    = (mul_product_s == {XLEN{1'b0}});
      illegal_nxt_s = 1'b0;
    end else begin
      result_nxt_s  = result_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      result_r    <= result_nxt_s;
      zero_r      <= zero_nxt_s;
      illegal_r   <= illegal_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
    end
  end

  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule
